// File: rtl/dc_arb_pkg.sv
// Shared types and parameter defaults for the downconverter stream arbiter.
// Imported by the arbiter top and its output buffer.
package dc_arb_pkg;

    localparam int N_REQ_DEF     = 4;
    localparam int DATA_W_DEF    = 32;
    localparam int BURST_MAX_DEF = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/dc_skid_buf.sv
// Two-entry in-order output buffer; the head entry drives the outputs directly,
// so a write into an empty buffer is visible on the next cycle.
module dc_skid_buf
    import dc_arb_pkg::*;
#(
    parameter int WIDTH = DATA_W_DEF + 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic [1:0]       count;
    logic             pop_ok;
    logic             push_ok;

    assign pop_ok  = i_pop && (count != 2'd0);
    assign push_ok = i_push && ((count != 2'd2) || pop_ok);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else begin
            unique case (1'b1)
                push_ok && !pop_ok: begin
                    if (count == 2'd0) head <= i_data;
                    else               tail <= i_data;
                    count <= count + 2'd1;
                end
                !push_ok && pop_ok: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                push_ok && pop_ok: begin
                    // Occupancy unchanged: refill behind the departing head
                    if (count == 2'd1) begin
                        head <= i_data;
                    end else begin
                        head <= tail;
                        tail <= i_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_data  = head;
    assign o_valid = (count != 2'd0);
    assign o_count = count;

endmodule

// File: rtl/dc_stream_arbiter.sv
// Round-robin burst arbiter feeding one downconverter from N_REQ streams.
// Grants last up to BURST_MAX beats and drain through a 2-entry buffer.
module dc_stream_arbiter
    import dc_arb_pkg::*;
#(
    parameter int N_REQ     = N_REQ_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int BURST_MAX = BURST_MAX_DEF
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [N_REQ*DATA_W-1:0]   i_req_data,
    input  logic [N_REQ-1:0]          i_req_valid,
    output logic [N_REQ-1:0]          o_req_ready,
    output logic [DATA_W-1:0]         o_data,
    output logic [$clog2(N_REQ)-1:0]  o_src,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic                      o_last,
    output logic                      o_busy
);

    localparam int SRC_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(BURST_MAX + 1);
    localparam int BUF_W = DATA_W + SRC_W + 1;

    arb_state_e         state;
    logic [SRC_W-1:0]   rr_ptr;
    logic [SRC_W-1:0]   gnt;
    logic [CNT_W-1:0]   beat_cnt;
    logic [N_REQ-1:0]   ready_q;

    logic [SRC_W-1:0]   pick;
    logic [SRC_W:0]     sum;
    logic [N_REQ-1:0]   pick_oh;
    logic [N_REQ-1:0]   gnt_oh;
    logic               acc;
    logic               last_beat;
    logic               pop;
    logic [1:0]         cnt;
    logic [1:0]         cnt_nx;
    logic [BUF_W-1:0]   buf_in;
    logic [BUF_W-1:0]   buf_out;

    // First valid requester at or above rr_ptr, wrapping
    always_comb begin
        pick = '0;
        sum  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            sum = {1'b0, rr_ptr} + (SRC_W+1)'(i);
            if (sum >= (SRC_W+1)'(N_REQ)) sum = sum - (SRC_W+1)'(N_REQ);
            if (i_req_valid[sum[SRC_W-1:0]]) pick = sum[SRC_W-1:0];
        end
    end

    assign pick_oh   = N_REQ'(1) << pick;
    assign gnt_oh    = N_REQ'(1) << gnt;
    assign acc       = |(ready_q & i_req_valid);
    assign last_beat = (beat_cnt == CNT_W'(BURST_MAX - 1));
    assign pop       = o_valid && i_ready;
    assign cnt_nx    = cnt + {1'b0, acc} - {1'b0, pop};

    assign buf_in = {last_beat, gnt,
                     i_req_data[gnt*DATA_W +: DATA_W]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            gnt      <= '0;
            beat_cnt <= '0;
            ready_q  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    ready_q <= '0;
                    if (|i_req_valid) begin
                        state    <= GRANT;
                        gnt      <= pick;
                        beat_cnt <= '0;
                        ready_q  <= (cnt_nx != 2'd2) ? pick_oh : '0;
                    end
                end
                GRANT: begin
                    if (acc) beat_cnt <= beat_cnt + CNT_W'(1);
                    if (!i_req_valid[gnt] || (acc && last_beat)) begin
                        state   <= IDLE;
                        ready_q <= '0;
                        rr_ptr  <= (gnt == SRC_W'(N_REQ - 1)) ?
                                   '0 : gnt + SRC_W'(1);
                    end else begin
                        // Registered "not full" for the coming cycle
                        ready_q <= (cnt_nx != 2'd2) ? gnt_oh : '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    dc_skid_buf #(
        .WIDTH (BUF_W)
    ) u_buf (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (acc),
        .i_data  (buf_in),
        .i_pop   (i_ready),
        .o_data  (buf_out),
        .o_valid (o_valid),
        .o_count (cnt)
    );

    assign {o_last, o_src, o_data} = buf_out;
    assign o_req_ready = ready_q;
    assign o_busy      = (state == GRANT);

endmodule

// File: tb/tb_dc_stream_arbiter.sv
// Directed bench for dc_stream_arbiter with a beat scoreboard
// and literal grant-order expectations.
module tb_dc_stream_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int BM = 16;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [DW-1:0]   o_data;
    logic [SW-1:0]   o_src;
    logic            o_valid;
    logic            ready;
    logic            o_last;
    logic            o_busy;

    always #5 clk = ~clk;

    dc_stream_arbiter #(
        .N_REQ     (N),
        .DATA_W    (DW),
        .BURST_MAX (BM)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_data  (req_data),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .o_data      (o_data),
        .o_src       (o_src),
        .o_valid     (o_valid),
        .i_ready     (ready),
        .o_last      (o_last),
        .o_busy      (o_busy)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic [SW-1:0] s;
        logic          l;
    } beat_t;

    int    n_assert = 0;
    int    n_fail   = 0;
    beat_t exp_q[$];
    int    log_src[$];
    bit    log_last[$];
    int    sent[N];
    int    quota[N];
    int    run[N];
    int    acc_in  = 0;
    int    acc_out = 0;
    bit    stall   = 1'b0;
    logic [DW+SW:0] held;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(int k, int n);
        return {8'(k), 24'(n)};
    endfunction

    function automatic bit drained();
        for (int k = 0; k < N; k++)
            if (sent[k] != quota[k]) return 1'b0;
        return (exp_q.size() == 0) && !o_valid;
    endfunction

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            req_valid[k] = (sent[k] < quota[k]);
            req_data[k*DW +: DW] = mk(k, sent[k]);
        end
    endtask

    // One clock: predict accepted beats before the edge, advance sources after
    task automatic cycle();
        logic [N-1:0] hs;
        @(negedge clk);
        hs = req_valid & req_ready;
        if (rst_n) begin
            for (int k = 0; k < N; k++) begin
                if (!req_valid[k]) run[k] = 0;
                if (hs[k]) begin
                    run[k]++;
                    exp_q.push_back('{mk(k, sent[k]), SW'(k), run[k] == BM});
                    if (run[k] == BM) run[k] = 0;
                    acc_in++;
                end
            end
        end
        @(posedge clk);
        #1;
        if (rst_n)
            for (int k = 0; k < N; k++)
                if (hs[k]) sent[k]++;
        drive();
    endtask

    task automatic run_until_done(string name, int budget);
        int c;
        c = 0;
        while (c < budget && !drained()) begin
            cycle();
            c++;
        end
        check({name, "_drained"}, 64'(c < budget), 64'd1);
    endtask

    task automatic src_at(string name, int idx, int exp);
        if (idx < log_src.size())
            check(name, 64'(log_src[idx]), 64'(exp));
        else
            check({name, "_count"}, 64'(log_src.size()), 64'(idx + 1));
    endtask

    task automatic check_reset_outs(string name);
        check({name, "_valid"}, 64'(o_valid), 64'd0);
        check({name, "_rdy"}, 64'(req_ready), 64'd0);
        check({name, "_last"}, 64'(o_last), 64'd0);
        check({name, "_busy"}, 64'(o_busy), 64'd0);
        check({name, "_src"}, 64'(o_src), 64'd0);
        check({name, "_data"}, 64'(o_data), 64'd0);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            stall = 1'b0;
        end else begin
            check("ready_onehot", 64'($countones(req_ready) <= 1), 64'd1);
            if (stall) begin
                check("stall_valid", 64'(o_valid), 64'd1);
                check("stall_hold", 64'({o_last, o_src, o_data}), 64'(held));
            end
            if (o_valid && ready) begin
                acc_out++;
                log_src.push_back(int'(o_src));
                log_last.push_back(o_last);
                check("beat_expected", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("out_beat", 64'({o_last, o_src, o_data}),
                          64'({e.l, e.s, e.d}));
                end
            end
            stall = o_valid && !ready;
            held  = {o_last, o_src, o_data};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int nl;
        logic [5:0] lfsr;
        int c;

        ready     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        for (int k = 0; k < N; k++) begin
            sent[k]  = 0;
            quota[k] = 0;
            run[k]   = 0;
        end
        drive();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outs("reset");
        rst_n = 1'b1;

        // All four streaming: 0,1,2,3,0
        base = log_src.size();
        quota[0] += 32;
        for (int k = 1; k < N; k++) quota[k] += 16;
        drive();
        run_until_done("rr4", 500);
        check("rr4_count", 64'(log_src.size() - base), 64'd80);
        for (int i = 0; i < 80; i++) begin
            if (base + i < log_src.size()) begin
                check("rr4_src", 64'(log_src[base+i]), 64'((i / 16) % 4));
                check("rr4_last", 64'(log_last[base+i]), 64'(i % 16 == 15));
            end
        end
        cycle();
        cycle();
        check("rr4_busy_end", 64'(o_busy), 64'd0);

        // Requester 2 alone, 5 beats, valid drop
        base = log_src.size();
        quota[2] += 5;
        drive();
        cycle();
        check("r2_busy", 64'(o_busy), 64'd1);
        run_until_done("r2", 100);
        cycle();
        cycle();
        check("r2_count", 64'(log_src.size() - base), 64'd5);
        nl = 0;
        for (int i = base; i < log_src.size(); i++) begin
            check("r2_src", 64'(log_src[i]), 64'd2);
            nl += int'(log_last[i]);
        end
        check("r2_nolast", 64'(nl), 64'd0);
        check("r2_busy_end", 64'(o_busy), 64'd0);

        // rr_ptr now 3: requesters 0 and 3 -> 3 first
        base = log_src.size();
        quota[0] += 4;
        quota[3] += 4;
        drive();
        run_until_done("r03", 100);
        src_at("r03_first", base, 3);
        src_at("r03_second", base + 4, 0);

        // Leave rr_ptr at 2, then requesters 1 and 3 -> 3 first
        quota[1] += 3;
        drive();
        run_until_done("r1", 100);
        base = log_src.size();
        quota[1] += 3;
        quota[3] += 3;
        drive();
        run_until_done("r13", 100);
        src_at("r13_first", base, 3);
        src_at("r13_third", base + 2, 3);
        src_at("r13_fourth", base + 3, 1);

        // Ten-cycle downstream stall mid-burst
        base = log_src.size();
        quota[0] += 20;
        drive();
        repeat (5) cycle();
        ready = 1'b0;
        repeat (10) cycle();
        check("stall_buffered", 64'(acc_in - acc_out), 64'd2);
        check("stall_rdy", 64'(req_ready), 64'd0);
        check("stall_ovalid", 64'(o_valid), 64'd1);
        ready = 1'b1;
        run_until_done("stall", 200);
        check("stall_count", 64'(log_src.size() - base), 64'd20);
        if (base + 19 < log_src.size()) begin
            check("stall_last16", 64'(log_last[base+15]), 64'd1);
            check("stall_last20", 64'(log_last[base+19]), 64'd0);
        end

        // Single requester under an LFSR ready pattern
        base = log_src.size();
        quota[1] += 40;
        drive();
        lfsr = 6'h2A;
        c = 0;
        while (c < 800 && !drained()) begin
            ready = lfsr[0];
            lfsr  = {lfsr[4:0], lfsr[5] ^ lfsr[4]};
            cycle();
            c++;
        end
        ready = 1'b1;
        check("lfsr_drained", 64'(c < 800), 64'd1);
        check("lfsr_count", 64'(log_src.size() - base), 64'd40);
        nl = 0;
        for (int i = base; i < log_src.size(); i++) nl += int'(log_last[i]);
        check("lfsr_lasts", 64'(nl), 64'd2);

        // Reset with two beats buffered
        quota[1] += 10;
        ready = 1'b0;
        drive();
        repeat (6) cycle();
        check("rst_buffered", 64'(acc_in - acc_out), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outs("midrst");
        exp_q.delete();
        acc_in  = 0;
        acc_out = 0;
        for (int k = 0; k < N; k++) run[k] = 0;
        quota[1] = sent[1];
        quota[0] += 3;
        quota[3] += 3;
        ready = 1'b1;
        drive();
        @(posedge clk);
        #1;
        check_reset_outs("midrst_hold");
        rst_n = 1'b1;
        base = log_src.size();
        run_until_done("postrst", 100);
        check("postrst_count", 64'(log_src.size() - base), 64'd6);
        src_at("postrst_first", base, 0);
        src_at("postrst_fourth", base + 3, 3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
